// File: rtl/sram_arb_pkg.sv
// Shared constants and types for the two-port SRAM arbiter.
package sram_arb_pkg;
    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 32;
    localparam int PORT_IF     = 0;
    localparam int PORT_LSU    = 1;

    typedef enum logic {ARB, TURN} arb_state_e;
endpackage

// File: rtl/sram_arb_pick.sv
// Combinational winner selection for two requesters: round-robin or
// fixed priority (port 1 high) with a starvation guard for port 0.
module sram_arb_pick #(
    parameter bit RR_EN      = 1'b1,
    parameter int MAX_STREAK = 4,
    parameter int SW         = 3
) (
    input  logic [1:0]    i_req,
    input  logic          i_ptr,
    input  logic [SW-1:0] i_streak,
    output logic [1:0]    o_gnt
);
    logic w_low_wins;

    // On contention the low port wins if it was not granted last (RR),
    // or if the high port has used up its streak (fixed priority).
    assign w_low_wins = RR_EN ? i_ptr : (i_streak == SW'(MAX_STREAK));

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11)
            o_gnt = w_low_wins ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one registered SRAM port between instruction fetch (0) and LSU (1),
// with read->write bubble and 1-cycle response routing.
// Optional per-port grant / bubble counters under SRAM_ARB_STATS_EN.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter bit RR_EN      = 1'b1,
    parameter int MAX_STREAK = 4,
    parameter int TURN_CYC   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p0_req,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic                p0_we,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_gnt,
    output logic                p0_resp,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic                p1_we,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    output logic                p1_gnt,
    output logic                p1_resp,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic                io_sram_en,
    output logic                io_sram_we,
    output logic [ADDR_W-1:0]   io_sram_addr,
    output logic [DATA_W-1:0]   io_sram_din,
    output logic [DATA_W/8-1:0] io_sram_wmask,
    input  logic [DATA_W-1:0]   io_sram_dout
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]         stat_gnt0,
    output logic [31:0]         stat_gnt1,
    output logic [31:0]         stat_turn
`endif
);
    localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);

    arb_state_e    r_state;
    logic          r_ptr;
    logic [SW-1:0] r_streak;
    logic          r_prev_rd;
    logic          r_rsp_vld;
    logic          r_rsp_own;
    logic          r_rsp_we;

    logic [1:0]    w_cand;
    logic [1:0]    w_gnt;
    logic          w_cand_we;
    logic          w_bubble;

    sram_arb_pick #(
        .RR_EN      (RR_EN),
        .MAX_STREAK (MAX_STREAK),
        .SW         (SW)
    ) u_pick (
        .i_req    ({p1_req, p0_req}),
        .i_ptr    (r_ptr),
        .i_streak (r_streak),
        .o_gnt    (w_cand)
    );

    assign w_cand_we = w_cand[PORT_LSU] ? p1_we : p0_we;
    assign w_bubble  = (TURN_CYC != 0) && r_prev_rd && (|w_cand) && w_cand_we;
    // Grants are also gated by reset so every output is quiet while held.
    assign w_gnt     = (rst && r_state == ARB && !w_bubble) ? w_cand : 2'b00;
    assign p0_gnt    = w_gnt[PORT_IF];
    assign p1_gnt    = w_gnt[PORT_LSU];

    always_comb begin
        io_sram_en    = |w_gnt;
        io_sram_we    = 1'b0;
        io_sram_addr  = '0;
        io_sram_din   = '0;
        io_sram_wmask = '0;
        if (w_gnt[PORT_LSU]) begin
            io_sram_we    = p1_we;
            io_sram_addr  = p1_addr;
            io_sram_din   = p1_wdata;
            io_sram_wmask = p1_wmask;
        end else if (w_gnt[PORT_IF]) begin
            io_sram_we    = p0_we;
            io_sram_addr  = p0_addr;
            io_sram_din   = p0_wdata;
            io_sram_wmask = p0_wmask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ARB;
            r_ptr     <= 1'b1;
            r_streak  <= '0;
            r_prev_rd <= 1'b0;
            r_rsp_vld <= 1'b0;
            r_rsp_own <= 1'b0;
            r_rsp_we  <= 1'b0;
        end else begin
            r_prev_rd <= io_sram_en && !io_sram_we;
            r_rsp_vld <= io_sram_en;
            r_rsp_own <= w_gnt[PORT_LSU];
            r_rsp_we  <= io_sram_we;
            if (|w_gnt)
                r_ptr <= w_gnt[PORT_LSU];
            if (!p0_req || w_gnt[PORT_IF])
                r_streak <= '0;
            else if (w_gnt[PORT_LSU] && r_streak != SW'(MAX_STREAK))
                r_streak <= r_streak + 1'b1;
            case (r_state)
                ARB:  if (w_bubble) r_state <= TURN;
                TURN: r_state <= ARB;
                default: r_state <= ARB;
            endcase
        end
    end

    assign p0_resp  = r_rsp_vld && !r_rsp_own;
    assign p1_resp  = r_rsp_vld &&  r_rsp_own;
    assign p0_rdata = (p0_resp && !r_rsp_we) ? io_sram_dout : '0;
    assign p1_rdata = (p1_resp && !r_rsp_we) ? io_sram_dout : '0;

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_gnt0 <= '0;
            stat_gnt1 <= '0;
            stat_turn <= '0;
        end else begin
            if (w_gnt[PORT_IF] && stat_gnt0 != 32'hFFFF_FFFF)
                stat_gnt0 <= stat_gnt0 + 32'd1;
            if (w_gnt[PORT_LSU] && stat_gnt1 != 32'hFFFF_FFFF)
                stat_gnt1 <= stat_gnt1 + 32'd1;
            if (r_state == TURN && stat_turn != 32'hFFFF_FFFF)
                stat_turn <= stat_turn + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Random-stimulus bench for sram_port_arbiter: three configurations
// (RR+bubble, fixed-priority+bubble, RR without bubble) against a reference model.
module tb_sram_port_arbiter;
    localparam int AW = 20, DW = 32, MW = 4, NI = 3, MAXS = 4, NCYC = 600;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req   [NI][2];
    logic [AW-1:0] addr  [NI][2];
    logic          we    [NI][2];
    logic [DW-1:0] wdata [NI][2];
    logic [MW-1:0] wmask [NI][2];
    logic          gnt0 [NI], gnt1 [NI], rsp0 [NI], rsp1 [NI];
    logic [DW-1:0] rd0 [NI], rd1 [NI], dout [NI], sdin [NI];
    logic          sen [NI], swe [NI];
    logic [AW-1:0] saddr [NI];
    logic [MW-1:0] smask [NI];
`ifdef SRAM_ARB_STATS_EN
    logic [31:0]   sg0 [NI], sg1 [NI], stn [NI];
`endif

    for (genvar k = 0; k < NI; k++) begin : g_dut
        sram_port_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RR_EN(k != 1), .MAX_STREAK(MAXS),
            .TURN_CYC((k == 2) ? 0 : 1)
        ) u_dut (
            .clk(clk), .rst(rst),
            .p0_req(req[k][0]), .p0_addr(addr[k][0]), .p0_we(we[k][0]),
            .p0_wdata(wdata[k][0]), .p0_wmask(wmask[k][0]),
            .p0_gnt(gnt0[k]), .p0_resp(rsp0[k]), .p0_rdata(rd0[k]),
            .p1_req(req[k][1]), .p1_addr(addr[k][1]), .p1_we(we[k][1]),
            .p1_wdata(wdata[k][1]), .p1_wmask(wmask[k][1]),
            .p1_gnt(gnt1[k]), .p1_resp(rsp1[k]), .p1_rdata(rd1[k]),
            .io_sram_en(sen[k]), .io_sram_we(swe[k]), .io_sram_addr(saddr[k]),
            .io_sram_din(sdin[k]), .io_sram_wmask(smask[k]), .io_sram_dout(dout[k])
`ifdef SRAM_ARB_STATS_EN
            , .stat_gnt0(sg0[k]), .stat_gnt1(sg1[k]), .stat_turn(stn[k])
`endif
        );
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state, kept as plain integers per instance.
    int  m_last [NI], m_streak [NI], m_own [NI];
    bit  m_prev_rd [NI], m_turn [NI], m_pv [NI], m_pwe [NI], hold [NI][2];
    int  m_g0 [NI], m_g1 [NI], m_tn [NI];

    function automatic bit rr_of(int k);  return k != 1; endfunction
    function automatic bit tc_of(int k);  return k != 2; endfunction

    task automatic model_reset(input int k);
        m_last[k] = 1; m_streak[k] = 0; m_prev_rd[k] = 0; m_turn[k] = 0;
        m_pv[k] = 0; m_pwe[k] = 0; m_own[k] = 0;
        m_g0[k] = 0; m_g1[k] = 0; m_tn[k] = 0;
    endtask

    task automatic check_all_zero(input int k);
        chk($sformatf("k%0d rst gnt", k), {gnt1[k], gnt0[k]}, 0);
        chk($sformatf("k%0d rst sram", k), {sen[k], swe[k], saddr[k], smask[k]}, 0);
        chk($sformatf("k%0d rst din", k), sdin[k], 0);
        chk($sformatf("k%0d rst resp", k), {rsp1[k], rsp0[k]}, 0);
        chk($sformatf("k%0d rst rdata", k), {rd1[k], rd0[k]}, 0);
    endtask

    task automatic step_check(input int k);
        int cand, g;
        bit enter_turn;
        logic [DW-1:0] e_rd [2];
        cand = -1;
        if (req[k][0] && req[k][1]) begin
            if (rr_of(k)) cand = (m_last[k] == 0) ? 1 : 0;
            else          cand = (m_streak[k] == MAXS) ? 0 : 1;
        end else if (req[k][0]) cand = 0;
        else if (req[k][1]) cand = 1;
        g = -1;
        enter_turn = 0;
        if (m_turn[k]) g = -1;
        else if (cand >= 0 && tc_of(k) && m_prev_rd[k] && we[k][cand]) enter_turn = 1;
        else g = cand;

        chk($sformatf("k%0d gnt", k), {gnt1[k], gnt0[k]}, (g < 0) ? 0 : (1 << g));
        chk($sformatf("k%0d en", k), sen[k], g >= 0);
        chk($sformatf("k%0d we", k), swe[k], (g >= 0) ? we[k][g] : 1'b0);
        chk($sformatf("k%0d addr", k), saddr[k], (g >= 0) ? addr[k][g] : '0);
        chk($sformatf("k%0d din", k), sdin[k], (g >= 0) ? wdata[k][g] : '0);
        chk($sformatf("k%0d mask", k), smask[k], (g >= 0) ? wmask[k][g] : '0);
        chk($sformatf("k%0d resp", k), {rsp1[k], rsp0[k]}, m_pv[k] ? (1 << m_own[k]) : 0);
        for (int p = 0; p < 2; p++)
            e_rd[p] = (m_pv[k] && m_own[k] == p && !m_pwe[k]) ? dout[k] : '0;
        chk($sformatf("k%0d rdata0", k), rd0[k], e_rd[0]);
        chk($sformatf("k%0d rdata1", k), rd1[k], e_rd[1]);

        if (m_turn[k]) m_tn[k]++;
        m_pv[k]      = (g >= 0);
        m_own[k]     = (g >= 0) ? g : 0;
        m_pwe[k]     = (g >= 0) ? we[k][g] : 1'b0;
        m_prev_rd[k] = (g >= 0) && !we[k][g];
        if (!req[k][0] || g == 0) m_streak[k] = 0;
        else if (g == 1) m_streak[k]++;
        if (g >= 0) begin
            m_last[k] = g;
            hold[k][g] = 0;
            if (g == 0) m_g0[k]++; else m_g1[k]++;
        end
        m_turn[k] = enter_turn;
    endtask

    task automatic drive(input int k);
        for (int p = 0; p < 2; p++) begin
            if (!hold[k][p]) begin
                if ($urandom_range(99) < 75) begin
                    hold[k][p]  = 1;
                    req[k][p]   = 1'b1;
                    addr[k][p]  = AW'($urandom);
                    we[k][p]    = $urandom_range(1);
                    wdata[k][p] = $urandom;
                    wmask[k][p] = MW'($urandom);
                end else begin
                    req[k][p] = 1'b0;
                end
            end else if ($urandom_range(99) < 6) begin
                hold[k][p] = 0;
                req[k][p]  = 1'b0;
            end
        end
        dout[k] = $urandom;
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            model_reset(k);
            dout[k] = '0;
            for (int p = 0; p < 2; p++) begin
                hold[k][p] = 0; req[k][p] = 0; addr[k][p] = '0;
                we[k][p] = 0; wdata[k][p] = '0; wmask[k][p] = '0;
            end
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        for (int k = 0; k < NI; k++) drive(k);
        #1;
        for (int k = 0; k < NI; k++) check_all_zero(k);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            rst = (cyc == 300) ? 1'b0 : 1'b1;
            for (int k = 0; k < NI; k++) drive(k);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (!rst) begin
                    check_all_zero(k);
`ifdef SRAM_ARB_STATS_EN
                    chk($sformatf("k%0d rst stats", k), {sg0[k], sg1[k]}, 0);
`endif
                    model_reset(k);
                end else begin
                    step_check(k);
                end
            end
        end
`ifdef SRAM_ARB_STATS_EN
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("k%0d stat_gnt0", k), sg0[k], m_g0[k]);
            chk($sformatf("k%0d stat_gnt1", k), sg1[k], m_g1[k]);
            chk($sformatf("k%0d stat_turn", k), stn[k], m_tn[k]);
        end
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
